// File: rtl/switch_drive_ctrl_pkg.sv
// Shared types and defaults for the active-low switch drive controller.
package switch_drive_ctrl_pkg;

    localparam int unsigned TMR_W = 20;

    typedef logic [TMR_W-1:0] tmr_t;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_DLY = 2'd1,
        S_ON  = 2'd2
    } state_e;

    localparam tmr_t DEF_ON_DLY     = 20'd1000;
    localparam tmr_t DEF_MIN_ON     = 20'd5000;
    localparam tmr_t DEF_MIN_OFF    = 20'd5000;
    localparam tmr_t DEF_FB_TIMEOUT = 20'd2000;

endpackage

// File: rtl/switch_drive_ctrl_sw_min_timer.sv
// Loadable 20-bit down-counter that holds at zero; shared by the minimum on/off windows.
module sw_min_timer
    import switch_drive_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  tmr_t load_val_i,
    output logic zero_o,
    output logic next_zero_o
);

    tmr_t count_q, count_d;

    // NOTE: combinational blocks assign a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o      = (count_q == '0);
    assign next_zero_o = (count_d == '0);

endmodule

// File: rtl/switch_drive_ctrl.sv
// Drives an active-low switch enable with turn-on delay and anti-chatter min on/off times.
// Define SW_FB_CHECK_EN to add feedback supervision with a sticky fault.
module switch_drive_ctrl
    import switch_drive_ctrl_pkg::*;
#(
    parameter tmr_t ON_DLY     = DEF_ON_DLY,
    parameter tmr_t MIN_ON     = DEF_MIN_ON,
    parameter tmr_t MIN_OFF    = DEF_MIN_OFF,
    parameter tmr_t FB_TIMEOUT = DEF_FB_TIMEOUT
) (
    input  logic clk_in,
    input  logic rstn_i,
    input  logic sw_req,
    input  logic sw_fb,
    output logic sw_out,
    output logic sw_on,
    output logic busy,
    output logic fault
);

    state_e state_q, state_d;
    tmr_t   cnt_q, cnt_d;
    logic   sw_out_q, sw_on_q, busy_q;
    logic   fault_q, fault_d;
    logic   tmr_load, tmr_zero, tmr_next_zero;
    tmr_t   tmr_val;

`ifdef SW_FB_CHECK_EN
    logic fb_meta_q, fb_sync_q;

    // sw_fb is asynchronous; idle value 1 means "not closed".
    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            fb_meta_q <= 1'b1;
            fb_sync_q <= 1'b1;
        end else begin
            fb_meta_q <= sw_fb;
            fb_sync_q <= fb_meta_q;
        end
    end
`else
    logic unused_fb;
    assign unused_fb = sw_fb ^ (^FB_TIMEOUT);
`endif

    sw_min_timer u_min_timer (
        .clk_i       (clk_in),
        .rst_ni      (rstn_i),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .zero_o      (tmr_zero),
        .next_zero_o (tmr_next_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            S_OFF: begin
`ifdef SW_FB_CHECK_EN
                if (!sw_req) fault_d = 1'b0;
`endif
                if (sw_req && tmr_zero && !fault_q) begin
                    state_d = S_DLY;
                    cnt_d   = '0;
                end
            end
            S_DLY: begin
                // DLY spans ON_DLY+1 edges, so closure lands ON_DLY+1 edges after the request is sampled.
                if (!sw_req) begin
                    state_d = S_OFF;
                end else if (cnt_q == ON_DLY) begin
                    state_d  = S_ON;
                    cnt_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = MIN_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
`ifdef SW_FB_CHECK_EN
                if (!fb_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FB_TIMEOUT - 1'b1) begin
                    fault_d  = 1'b1;
                    state_d  = S_OFF;
                    cnt_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = MIN_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (state_d == S_ON && !sw_req && tmr_zero) begin
                    state_d  = S_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = MIN_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            sw_out_q <= 1'b1;
            sw_on_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sw_out_q <= (state_d != S_ON);
            sw_on_q  <= (state_d == S_ON);
            busy_q   <= (state_d == S_DLY) || !tmr_next_zero;
            fault_q  <= fault_d;
        end
    end

    assign sw_out = sw_out_q;
    assign sw_on  = sw_on_q;
    assign busy   = busy_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_switch_drive_ctrl.sv
// Scoreboard bench for switch_drive_ctrl with ON_DLY=4, MIN_ON=8, MIN_OFF=6, FB_TIMEOUT=5.
module tb_switch_drive_ctrl;
    import switch_drive_ctrl_pkg::*;

    localparam int ON_DLY  = 4;
    localparam int MIN_ON  = 8;
    localparam int MIN_OFF = 6;
    localparam int FB_TO   = 5;

    typedef struct packed {
        logic out;
        logic on;
        logic busy;
        logic fault;
    } obs_t;

    logic clk_in = 1'b0;
    logic rstn_i = 1'b1;
    logic sw_req = 1'b0;
    logic sw_fb  = 1'b1;
    logic sw_out, sw_on, busy, fault;

    obs_t sb[$];
    logic plan_req[$];
    obs_t plan_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    switch_drive_ctrl #(
        .ON_DLY     (20'd4),
        .MIN_ON     (20'd8),
        .MIN_OFF    (20'd6),
        .FB_TIMEOUT (20'd5)
    ) dut (
        .clk_in (clk_in),
        .rstn_i (rstn_i),
        .sw_req (sw_req),
        .sw_fb  (sw_fb),
        .sw_out (sw_out),
        .sw_on  (sw_on),
        .busy   (busy),
        .fault  (fault)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t obs();
        return {sw_out, sw_on, busy, fault};
    endfunction

    function automatic obs_t mk(input logic o, input logic n, input logic b, input logic f);
        return {o, n, b, f};
    endfunction

    task automatic add(input logic req, input obs_t e);
        plan_req.push_back(req);
        plan_exp.push_back(e);
    endtask

    task automatic clear_plan();
        plan_req.delete();
        plan_exp.delete();
    endtask

    // Inputs change 1 time unit after a rising edge, well away from the next sampling edge.
    task automatic apply_reset(input logic fb);
        sw_req = 1'b0;
        sw_fb  = fb;
        rstn_i = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic add_close();
        for (int i = 0; i <= ON_DLY; i++) add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0));
        add(1'b1, mk(1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic test_reset();
        obs_t e;
        sw_req = 1'b1;
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs(), e);
        end
    endtask

    task automatic test_turn_on();
        obs_t e;
        apply_reset(1'b0);
        clear_plan();
        for (int i = 0; i <= ON_DLY; i++) add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0));
        for (int m = 0; m <= MIN_ON + 1; m++) add(1'b1, mk(1'b0, 1'b1, m < MIN_ON, 1'b0));
        add(1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0));
        for (int m = 1; m <= MIN_OFF + 1; m++) add(1'b0, mk(1'b1, 1'b0, m < MIN_OFF, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL turn_on edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_abort();
        obs_t e;
        apply_reset(1'b0);
        clear_plan();
        for (int i = 0; i < 3; i++) add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0));
        add(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
        add_close();
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL abort edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_min_on();
        obs_t e;
        apply_reset(1'b0);
        clear_plan();
        add_close();
        for (int m = 1; m <= MIN_ON; m++) add((m == 1) || (m == 3), mk(1'b0, 1'b1, m < MIN_ON, 1'b0));
        add(1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL min_on edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    // Starts on the edge after a release, with the min-off window freshly loaded.
    task automatic test_back_to_back();
        obs_t e;
        clear_plan();
        for (int m = 1; m <= MIN_OFF; m++) add(1'b1, mk(1'b1, 1'b0, m < MIN_OFF, 1'b0));
        for (int m = 0; m <= ON_DLY; m++) add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0));
        add(1'b1, mk(1'b0, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL back_to_back edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_on();
        obs_t e;
        apply_reset(1'b0);
        clear_plan();
        add_close();
        add(1'b1, mk(1'b0, 1'b1, 1'b1, 1'b0));
        add(1'b1, mk(1'b0, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL pre_reset edge %0d: got %b want %b", i, obs(), e);
            end
        end
        #2;
        rstn_i = 1'b0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL async_reset: got %b want %b", obs(), e);
        end
        @(posedge clk_in);
        #1;
        rstn_i = 1'b1;
        clear_plan();
        add_close();
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL post_reset edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

`ifdef SW_FB_CHECK_EN
    task automatic test_fb_fault();
        obs_t e;
        apply_reset(1'b1);
        clear_plan();
        add_close();
        for (int m = 1; m < FB_TO; m++) add(1'b1, mk(1'b0, 1'b1, 1'b1, 1'b0));
        add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b1));
        for (int m = 1; m <= MIN_OFF + 2; m++) add(1'b1, mk(1'b1, 1'b0, m < MIN_OFF, 1'b1));
        add(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL fb_fault edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_fb_loss();
        obs_t e;
        apply_reset(1'b0);
        clear_plan();
        add_close();
        for (int m = 1; m <= MIN_ON + 2; m++) add(1'b1, mk(1'b0, 1'b1, m < MIN_ON, 1'b0));
        // Two sync edges plus FB_TO counting edges after sw_fb rises.
        for (int k = 0; k <= FB_TO; k++) add(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, mk(1'b1, 1'b0, 1'b1, 1'b1));
        for (int i = 0; i < plan_req.size(); i++) begin
            if (i == ON_DLY + MIN_ON + 4) sw_fb = 1'b1;
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL fb_loss edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask
`else
    task automatic test_fb_ignored();
        obs_t e;
        apply_reset(1'b1);
        clear_plan();
        add_close();
        for (int m = 1; m <= MIN_ON + 6; m++) add(1'b1, mk(1'b0, 1'b1, m < MIN_ON, 1'b0));
        for (int i = 0; i < plan_req.size(); i++) begin
            sw_req = plan_req[i];
            sb.push_back(plan_exp[i]);
            @(posedge clk_in);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL fb_ignored edge %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_turn_on();
        test_abort();
        test_min_on();
        test_back_to_back();
        test_reset_mid_on();
`ifdef SW_FB_CHECK_EN
        test_fb_fault();
        test_fb_loss();
`else
        test_fb_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
